// File: rtl/ex_div_if.sv
// Divider handshake bundle between the EX stage control and the iterative divider.
// Latency: none (pure signal grouping).
// Backpressure: pause_req from the divider holds ID/EX and upstream while it is busy.
//
// Ports / members:
//   start, signed_op, dividend, divisor, cancel  -- driven by the pipeline (master)
//   pause_req, done, quotient, remainder         -- driven by the divider (slave)
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             cancel;
    logic             pause_req;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_op, dividend, divisor, cancel,
        input  pause_req, done, quotient, remainder
    );

    modport slave (
        input  start, signed_op, dividend, divisor, cancel,
        output pause_req, done, quotient, remainder
    );
endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider (signed/unsigned) for the execute stage, one quotient bit per cycle.
// Latency: done in cycle WIDTH+1 after the start acceptance edge; cycle 1 for divide by zero.
// Backpressure: raises pause_req while an operation is accepted/in progress; cancel abandons it.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - ex_div_if.slave: start/signed_op/dividend/divisor/cancel in,
//          pause_req/done/quotient/remainder out
module ex_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] prem;      // partial remainder
    logic [WIDTH-1:0] work;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs;       // |divisor|
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;

    // Operand preparation for the IDLE acceptance cycle.
    logic             accept;
    logic             div_zero;
    logic             dvd_sgn;
    logic             dvs_sgn;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;

    always_comb begin
        accept   = (state == IDLE) && bus.start && !bus.cancel;
        div_zero = (bus.divisor == '0);
        dvd_sgn  = bus.signed_op && bus.dividend[WIDTH-1];
        dvs_sgn  = bus.signed_op && bus.divisor[WIDTH-1];
        dvd_abs  = dvd_sgn ? -bus.dividend : bus.dividend;
        dvs_abs  = dvs_sgn ? -bus.divisor  : bus.divisor;
    end

    // One restoring step. The shifted value is WIDTH+1 bits wide so the
    // carry out of the partial remainder takes part in the compare; when it
    // is set the difference still fits in WIDTH bits.
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             last_step;

    always_comb begin
        shifted   = {prem, work[WIDTH-1]};
        ge        = (shifted >= {1'b0, dvs});
        rem_step  = ge ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
        quo_step  = {work[WIDTH-2:0], ge};
        last_step = (cnt == CNT_W'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; cancel overrides everything.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.cancel) begin
            state_nxt = IDLE;
        end
    end

    // Outputs
    always_comb begin
        bus.pause_req = !bus.cancel &&
                        (((state == IDLE) && bus.start) || (state == CALC));
        bus.done      = (state == DONE);
        bus.quotient  = quo_r;
        bus.remainder = rem_r;
    end

    // Datapath. Results only update on completion, so a cancelled operation
    // leaves the previous quotient/remainder visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            prem  <= '0;
            work  <= '0;
            dvs   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            quo_r <= '0;
            rem_r <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (div_zero) begin
                            quo_r <= '1;
                            rem_r <= bus.dividend;
                        end else begin
                            work  <= dvd_abs;
                            dvs   <= dvs_abs;
                            q_neg <= dvd_sgn ^ dvs_sgn;
                            r_neg <= dvd_sgn;
                            cnt   <= '0;
                            prem  <= '0;
                        end
                    end
                end
                CALC: begin
                    if (!bus.cancel) begin
                        prem <= rem_step;
                        work <= quo_step;
                        cnt  <= cnt + CNT_W'(1);
                        if (last_step) begin
                            quo_r <= q_neg ? -quo_step : quo_step;
                            rem_r <= r_neg ? -rem_step : rem_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed corner cases plus randomized divides vs a reference model.
// Latency: checks done at cycle 33 (1 for divide by zero) from the start acceptance edge.
// Backpressure: checks pause_req high for every busy cycle and low in the done cycle.
module tb_ex_div;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ex_div_if #(.WIDTH(W)) bus();

    ex_div #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int mis = 0;

    // Reference: plain 64-bit arithmetic. SV integer division truncates toward
    // zero and % takes the sign of the dividend; 64 bits avoid INT_MIN/-1 overflow.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic [31:0] q, output logic [31:0] r, output int lat);
        longint x, y, qq, rr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            lat = 1;
        end else begin
            if (s) begin
                x = $signed(a);
                y = $signed(b);
            end else begin
                x = {32'd0, a};
                y = {32'd0, b};
            end
            qq = x / y;
            rr = x % y;
            q = 32'(qq);
            r = 32'(rr);
            lat = W + 1;
        end
    endtask

    // Launch one operation with start held until done; report what was seen.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                           output logic [31:0] q, output logic [31:0] r,
                           output int lat, output bit pause_ok);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        lat = -1;
        pause_ok = 1'b1;
        q = 'x;
        r = 'x;
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = c;
                q = bus.quotient;
                r = bus.remainder;
                if (bus.pause_req) pause_ok = 1'b0;
                break;
            end
            if (!bus.pause_req) pause_ok = 1'b0;
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vec++; if (bus.quotient !== 32'd0) begin mis++; $display("FAIL reset_q: got %h want 0", bus.quotient); end
        vec++; if (bus.remainder !== 32'd0) begin mis++; $display("FAIL reset_r: got %h want 0", bus.remainder); end
        vec++; if (bus.done !== 1'b0) begin mis++; $display("FAIL reset_done: got %b want 0", bus.done); end
        vec++; if (bus.pause_req !== 1'b0) begin mis++; $display("FAIL reset_pause: got %b want 0", bus.pause_req); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [31:0] q, r; int lat; bit pok;
        run_div(32'd100, 32'd7, 1'b0, q, r, lat, pok);
        vec++; if (lat != 33) begin mis++; $display("FAIL u100_7_lat: got %0d want 33", lat); end
        vec++; if (q !== 32'd14) begin mis++; $display("FAIL u100_7_q: got %h want %h", q, 32'd14); end
        vec++; if (r !== 32'd2) begin mis++; $display("FAIL u100_7_r: got %h want %h", r, 32'd2); end
        vec++; if (!pok) begin mis++; $display("FAIL u100_7_pause: got bad profile want high 0..32 low 33"); end
        @(negedge clk);
        vec++; if (bus.done !== 1'b0) begin mis++; $display("FAIL done_one_cycle: got %b want 0", bus.done); end
    endtask

    task automatic test_signed();
        logic [31:0] q, r; int lat; bit pok;
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, lat, pok);
        vec++; if (q !== 32'hFFFF_FFFD) begin mis++; $display("FAIL sm7_2_q: got %h want fffffffd", q); end
        vec++; if (r !== 32'hFFFF_FFFF) begin mis++; $display("FAIL sm7_2_r: got %h want ffffffff", r); end
        run_div(32'd7, 32'hFFFF_FFFE, 1'b1, q, r, lat, pok);
        vec++; if (q !== 32'hFFFF_FFFD) begin mis++; $display("FAIL s7_m2_q: got %h want fffffffd", q); end
        vec++; if (r !== 32'd1) begin mis++; $display("FAIL s7_m2_r: got %h want 1", r); end
        vec++; if (lat != 33) begin mis++; $display("FAIL s7_m2_lat: got %0d want 33", lat); end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r; int lat; bit pok;
        for (int s = 0; s < 2; s++) begin
            run_div(32'd5, 32'd0, s[0], q, r, lat, pok);
            vec++; if (lat != 1) begin mis++; $display("FAIL dz%0d_lat: got %0d want 1", s, lat); end
            vec++; if (q !== 32'hFFFF_FFFF) begin mis++; $display("FAIL dz%0d_q: got %h want ffffffff", s, q); end
            vec++; if (r !== 32'd5) begin mis++; $display("FAIL dz%0d_r: got %h want 5", s, r); end
            vec++; if (!pok) begin mis++; $display("FAIL dz%0d_pause: got bad profile want high only cycle 0", s); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] q, r; int lat; bit pok;
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, lat, pok);
        vec++; if (q !== 32'h8000_0000) begin mis++; $display("FAIL ovf_q: got %h want 80000000", q); end
        vec++; if (r !== 32'd0) begin mis++; $display("FAIL ovf_r: got %h want 0", r); end
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, q, r, lat, pok);
        vec++; if (q !== 32'hFFFF_FFFF) begin mis++; $display("FAIL umax_q: got %h want ffffffff", q); end
        vec++; if (r !== 32'd0) begin mis++; $display("FAIL umax_r: got %h want 0", r); end
    endtask

    task automatic test_cancel();
        logic [31:0] q, r; int lat; bit pok; int seen;
        run_div(32'd20, 32'd6, 1'b0, q, r, lat, pok);
        vec++; if (q !== 32'd3 || r !== 32'd2) begin mis++; $display("FAIL pre_cancel: got %h/%h want 3/2", q, r); end
        @(posedge clk); #1;
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        bus.cancel = 1'b1;
        @(negedge clk);
        vec++; if (bus.pause_req !== 1'b0) begin mis++; $display("FAIL cancel_pause_c10: got %b want 0", bus.pause_req); end
        @(posedge clk); #1;
        bus.cancel = 1'b0;
        bus.start  = 1'b0;
        @(negedge clk);
        vec++; if (bus.pause_req !== 1'b0) begin mis++; $display("FAIL cancel_pause_c11: got %b want 0", bus.pause_req); end
        vec++; if (bus.quotient !== 32'd3) begin mis++; $display("FAIL cancel_q_kept: got %h want 3", bus.quotient); end
        vec++; if (bus.remainder !== 32'd2) begin mis++; $display("FAIL cancel_r_kept: got %h want 2", bus.remainder); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        vec++; if (seen != 0) begin mis++; $display("FAIL cancel_no_done: got %0d done cycles want 0", seen); end
        run_div(32'd9, 32'd3, 1'b0, q, r, lat, pok);
        vec++; if (lat != 33) begin mis++; $display("FAIL post_cancel_lat: got %0d want 33", lat); end
        vec++; if (q !== 32'd3 || r !== 32'd0) begin mis++; $display("FAIL post_cancel_res: got %h/%h want 3/0", q, r); end
    endtask

    task automatic test_start_cancel_idle();
        int seen;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.cancel = 1'b1; bus.signed_op = 1'b0;
        bus.dividend = 32'd10; bus.divisor = 32'd3;
        @(negedge clk);
        vec++; if (bus.pause_req !== 1'b0) begin mis++; $display("FAIL sc_idle_pause: got %b want 0", bus.pause_req); end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.cancel = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.pause_req) seen++;
        end
        vec++; if (seen != 0) begin mis++; $display("FAIL sc_idle_stays: got %0d busy cycles want 0", seen); end
    endtask

    task automatic test_async_reset();
        logic [31:0] q, r; int lat; bit pok; int seen;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.signed_op = 1'b0; bus.dividend = 32'd50000; bus.divisor = 32'd13;
        repeat (17) @(posedge clk);
        #3;
        rst = 1'b0;
        bus.start = 1'b0;
        #1;
        vec++; if (bus.quotient !== 32'd0) begin mis++; $display("FAIL arst_q: got %h want 0", bus.quotient); end
        vec++; if (bus.remainder !== 32'd0) begin mis++; $display("FAIL arst_r: got %h want 0", bus.remainder); end
        vec++; if (bus.pause_req !== 1'b0) begin mis++; $display("FAIL arst_pause: got %b want 0", bus.pause_req); end
        vec++; if (bus.done !== 1'b0) begin mis++; $display("FAIL arst_done: got %b want 0", bus.done); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done || bus.pause_req) seen++;
        end
        vec++; if (seen != 0) begin mis++; $display("FAIL arst_idle_after: got %0d busy cycles want 0", seen); end
        run_div(32'd12345, 32'd67, 1'b0, q, r, lat, pok);
        vec++; if (lat != 33 || q !== 32'd184 || r !== 32'd17) begin
            mis++; $display("FAIL arst_recover: got lat %0d %h/%h want 33 000000b8/00000011", lat, q, r);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, q, r, eq, er; int lat, elat; bit pok;
        for (int i = 0; i < 3; i++) begin
            a = $urandom;
            b = $urandom_range(1, 1000);
            model(a, b, i[0], eq, er, elat);
            run_div(a, b, i[0], q, r, lat, pok);
            vec++; if (lat != elat || q !== eq || r !== er) begin
                mis++; $display("FAIL b2b_%0d: got lat %0d %h/%h want %0d %h/%h", i, lat, q, r, elat, eq, er);
            end
            vec++; if (!pok) begin mis++; $display("FAIL b2b_%0d_pause: got bad profile want busy-high done-low", i); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er; int lat, elat; bit pok, s;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            s = $urandom_range(0, 1);
            model(a, b, s, eq, er, elat);
            run_div(a, b, s, q, r, lat, pok);
            vec++; if (q !== eq || r !== er) begin
                mis++; $display("FAIL rnd_%0d %h/%h s%0d: got %h/%h want %h/%h", i, a, b, s, q, r, eq, er);
            end
            vec++; if (lat != elat || !pok) begin
                mis++; $display("FAIL rnd_%0d_timing: got lat %0d pause_ok %0d want %0d 1", i, lat, pok, elat);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.cancel    = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_cancel();
        test_start_cancel_idle();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
